// File: rtl/decoder_grant_arbiter_if.sv
// decoder_grant_arbiter_if
//   Bundle of the request/grant signals shared between the requesting agents
//   and the round-robin decoder arbiter.
//
//   req      [3:0]  request, bit i = requester i
//   done     [3:0]  completion strobe, only the current owner's bit matters
//   sel      [1:0]  decoder select (sel[1] = A, sel[0] = B)
//   en              decoder positive enable
//   grant_n  [3:0]  active-low one-hot grant (decoder outputs)
//   busy            arbiter is in GRANT or RELEASE
//   timeout         one-cycle pulse on a hold-limit release
//
//   master : arbiter side (drives the decoder and status)
//   slave  : requester side (drives req/done)
interface decoder_grant_arbiter_if;
    logic [3:0] req;
    logic [3:0] done;
    logic [1:0] sel;
    logic       en;
    logic [3:0] grant_n;
    logic       busy;
    logic       timeout;

    modport master (
        input  req,
        input  done,
        output sel,
        output en,
        output grant_n,
        output busy,
        output timeout
    );

    modport slave (
        output req,
        output done,
        input  sel,
        input  en,
        input  grant_n,
        input  busy,
        input  timeout
    );
endinterface

// File: rtl/decoder_grant_arbiter.sv
// decoder_grant_arbiter
//   Round-robin arbiter sharing a 2x4 negative-output, positive-enable decoder
//   among four requesters. The registered sel/en drive the decoder, whose
//   active-low outputs form the one-hot grant bus. A grant is held until the
//   owner strobes done, drops its request, or has held for MAX_HOLD cycles.
//   Every release is followed by one RELEASE cycle and one IDLE cycle, so two
//   owners are always separated by at least two cycles of grant_n = 4'b1111.
//
//   Parameters
//     MAX_HOLD  maximum grant length in cycles, 1..255
//   Ports
//     clk       rising-edge clock
//     rst       synchronous active-high reset
//     bus       decoder_grant_arbiter_if.master (req/done in; sel, en,
//               grant_n, busy, timeout out)
module decoder_grant_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    decoder_grant_arbiter_if.master        bus
);

    localparam logic [7:0] MaxHoldCnt = 8'(MAX_HOLD);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StRelease
    } state_e;

    state_e     state_q;
    logic [1:0] sel_q;
    logic [1:0] last_q;
    logic       en_q;
    logic       busy_q;
    logic       timeout_q;
    logic [7:0] hold_q;

    logic [1:0] winner;
    logic [1:0] cand;
    logic       found;
    logic       owner_done;
    logic       owner_drop;
    logic       hold_max;

    // Round-robin pick: scan last+1, last+2, last+3, last (the previous owner
    // is checked last, so it loses to any other requester).
    always_comb begin
        winner = last_q + 2'd1;
        cand   = '0;
        found  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        owner_done = bus.done[sel_q];
        owner_drop = ~bus.req[sel_q];
        hold_max   = (hold_q == MaxHoldCnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            sel_q     <= 2'b00;
            last_q    <= 2'd3;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    timeout_q <= 1'b0;
                    if (|bus.req) begin
                        sel_q   <= winner;
                        last_q  <= winner;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        hold_q  <= 8'd1;
                        state_q <= StGrant;
                    end
                end
                StGrant: begin
                    if (owner_done || owner_drop || hold_max) begin
                        en_q      <= 1'b0;
                        state_q   <= StRelease;
                        // Only a pure hold-limit release counts as a timeout.
                        timeout_q <= hold_max & ~owner_done & ~owner_drop;
                    end else if (hold_q < MaxHoldCnt) begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                StRelease: begin
                    timeout_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    en_q      <= 1'b0;
                    busy_q    <= 1'b0;
                    timeout_q <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    // The decoder itself: only en gates the outputs, sel keeps its value.
    assign bus.grant_n = en_q ? ~(4'b0001 << sel_q) : 4'b1111;
    assign bus.sel     = sel_q;
    assign bus.en      = en_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule

// File: doc/decoder_grant_arbiter.md
# decoder_grant_arbiter

Round-robin arbiter that shares the 2x4 negative-output, positive-enable decoder among four requesters. It sequences the decoder's select inputs and enable, so the decoder's active-low outputs act as a one-hot grant bus. Each grant is held until the owner signals completion, drops its request, or exceeds a hold limit. It sits between the requesting agents and the structural decoder and is the only block that drives the decoder's select and enable pins.

## Interface
- MAX_HOLD, 8, maximum cycles a single grant may be held; legal range 1..255
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  4  request, one bit per requester; bit i = requester i
- done  input  4  owner completion strobe; only the current owner's bit is honoured
- sel  output  2  decoder select (sel[1] = A, sel[0] = B); registered
- en  output  1  decoder positive enable; registered
- grant_n  output  4  active-low one-hot grant; equals the decoder output: ~(4'b0001 << sel) when en=1, else 4'b1111
- busy  output  1  high while state is GRANT or RELEASE
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - en=0.
  - If req != 0 at a rising edge, pick the winner by round-robin starting at (last+1) mod 4.
  - Load sel=winner, en=1, last=winner, hold_cnt=1, and go to GRANT.
  - If req == 0, stay in IDLE.
- GRANT (owner = sel):
  - Release when any of these is true at the edge:
    - done[sel]=1
    - req[sel]=0
    - hold_cnt==MAX_HOLD
  - On release: en=0 and go to RELEASE.
  - timeout=1 in the RELEASE cycle only when the release was caused by hold_cnt alone.
  - Otherwise hold_cnt increments (8-bit, saturating at MAX_HOLD).
- RELEASE:
  - Always one cycle: en=0, grant_n=4'b1111, then go to IDLE.
  - Guarantees a one-cycle break-before-make gap between owners.
- Simultaneous events:
  - done[sel] in the same cycle as hold_cnt==MAX_HOLD counts as normal completion: timeout stays 0.
  - done bits of non-owners are ignored in every state.
  - done in IDLE or RELEASE has no effect.
  - A request arriving during GRANT or RELEASE waits for IDLE.
  - The current owner re-requesting after release gets lowest priority if others request.
- Round-robin pointer `last`:
  - Updated only on grant.
  - Wraps 3 -> 0.
  - Reset value 3, so requester 0 has highest priority after reset.
- sel holds its last value while en=0. Only en gates grant_n.

## Timing
- Reset values: state=IDLE, sel=2'b00, en=0, grant_n=4'b1111, busy=0, timeout=0, last=3, hold_cnt=0.
- Reset mid-grant: at the first edge with rst=1, en drops to 0 and grant_n goes to 4'b1111. No timeout pulse. Pointer returns to 3.
- Request-to-grant latency: req high before edge k -> grant_n low after edge k (1 cycle).
- Grant duration:
  - Minimum 1 cycle (done already high in the first GRANT cycle).
  - Maximum MAX_HOLD cycles.
- Release sequence: release condition seen at edge m -> en=0 after edge m (RELEASE) -> IDLE after edge m+1 -> next grant after edge m+2 at the earliest.
- Owner-to-owner gap: 2 cycles of grant_n=4'b1111 minimum.
- grant_n is combinational from the registered sel/en (the decoder itself). No other output has a combinational path from an input.

## Test plan
- Reset then req=4'b0100 held, done=0, MAX_HOLD=8 -> sel=2'b10, en=1, grant_n=4'b1011 one cycle after request. Grant holds 8 cycles. Then en=0 with timeout=1 for exactly one cycle.
- req=4'b1111 held, owner pulses done after 2 cycles each -> grant order 0,1,2,3,0. grant_n sequence 1110,1101,1011,0111,1110, with 2 idle cycles (1111) between each.
- Owner 1 granted, then done=4'b0001 (non-owner) -> no release. Then req[1] dropped -> release next edge, timeout=0.
- done[sel] asserted exactly when hold_cnt==MAX_HOLD -> release with timeout=0.
- rst=1 asserted during GRANT of requester 2 -> after that edge grant_n=1111, en=0, sel=00, busy=0. With req=4'b0101 after reset, requester 0 is granted first.
- MAX_HOLD=1, req=4'b0010 held -> alternating 1-cycle grant (grant_n=1101), timeout pulse, and IDLE, repeating every 3 cycles.
